// File: rtl/dpwm_sequencer_if.sv
// Control/status bundle between the compensator/DPWM side and the DPWM sequencer.
// The master side drives run/duty/period/fault; the sequencer (slave) returns duty word and status.
interface dpwm_sequencer_if;
  logic       enable;
  logic [8:0] duty_cmd;
  logic       cmd_valid;
  logic       period_start;
  logic       fault;
  logic [8:0] ditherin;
  logic       pwm_en;
  logic [1:0] state;
  logic       ss_done;

  modport master (
    output enable, duty_cmd, cmd_valid, period_start, fault,
    input  ditherin, pwm_en, state, ss_done
  );

  modport slave (
    input  enable, duty_cmd, cmd_valid, period_start, fault,
    output ditherin, pwm_en, state, ss_done
  );
endinterface

// File: rtl/dpwm_sequencer.sv
// Start-up / run / fault-recovery sequencer in front of the dithered DPWM.
// Soft-start ramp, per-period duty updates, duty clamping and timed fault hold-off.
module dpwm_sequencer #(
  parameter logic [8:0]  DUTY_MAX     = 9'd480,
  parameter logic [8:0]  SS_STEP      = 9'd4,
  parameter int unsigned RAMP_PERIODS = 8,
  parameter int unsigned HOLDOFF      = 64
) (
  input logic             clk,
  input logic             rst,
  dpwm_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_SOFTSTART = 2'b01,
    ST_RUN       = 2'b10,
    ST_FAULT     = 2'b11
  } state_e;

  localparam logic [7:0] TICK_LAST = 8'(RAMP_PERIODS - 1);
  localparam logic [9:0] HOLD_LAST = 10'(HOLDOFF - 1);

  function automatic logic [8:0] clamp(input logic [8:0] x);
    return (x > DUTY_MAX) ? DUTY_MAX : x;
  endfunction

  state_e     state_q,    state_d;
  logic [8:0] ditherin_q, ditherin_d;
  logic       pwm_en_q,   pwm_en_d;
  logic       ss_done_q,  ss_done_d;
  logic [8:0] target_q,   target_d;
  logic [8:0] ramp_q,     ramp_d;
  logic [7:0] tick_q,     tick_d;
  logic [9:0] hold_q,     hold_d;

  logic [8:0] cmd_clamped;
  logic [9:0] ramp_sum;
  logic [8:0] ramp_step;

  assign cmd_clamped = clamp(bus.duty_cmd);

  // Ten-bit sum so a ramp near the top of the range cannot wrap before the min().
  assign ramp_sum  = {1'b0, ramp_q} + {1'b0, SS_STEP};
  assign ramp_step = (ramp_sum > {1'b0, target_q}) ? target_q : ramp_sum[8:0];

  always_comb begin
    // NOTE: every signal gets a default before any branching so no path leaves it unassigned (no latches).
    state_d    = state_q;
    ditherin_d = ditherin_q;
    ramp_d     = ramp_q;
    tick_d     = tick_q;
    hold_d     = hold_q;
    target_d   = bus.cmd_valid ? cmd_clamped : target_q;

    if (bus.fault) begin
      // Fault overrides everything and also restarts the hold-off while it persists.
      state_d    = ST_FAULT;
      ditherin_d = '0;
      ramp_d     = '0;
      tick_d     = '0;
      hold_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ditherin_d = '0;
          ramp_d     = '0;
          tick_d     = '0;
          if (bus.enable) state_d = ST_SOFTSTART;
        end

        ST_SOFTSTART: begin
          if (!bus.enable) begin
            state_d    = ST_IDLE;
            ditherin_d = '0;
            ramp_d     = '0;
            tick_d     = '0;
          end else if (bus.period_start) begin
            if (ramp_q == target_q) begin
              state_d    = ST_RUN;
              tick_d     = '0;
              ditherin_d = ramp_q;
            end else if (tick_q == TICK_LAST) begin
              tick_d     = '0;
              ramp_d     = ramp_step;
              ditherin_d = ramp_step;
            end else begin
              tick_d = tick_q + 8'd1;
            end
          end
        end

        ST_RUN: begin
          if (!bus.enable) begin
            state_d    = ST_IDLE;
            ditherin_d = '0;
            ramp_d     = '0;
            tick_d     = '0;
          end else if (bus.period_start) begin
            // A command landing on the boundary itself is taken immediately.
            ditherin_d = bus.cmd_valid ? cmd_clamped : target_q;
          end
        end

        ST_FAULT: begin
          ditherin_d = '0;
          if (bus.period_start) begin
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              ramp_d  = '0;
              tick_d  = '0;
              state_d = bus.enable ? ST_SOFTSTART : ST_IDLE;
            end else begin
              hold_d = hold_q + 10'd1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    pwm_en_d  = (state_d == ST_SOFTSTART) || (state_d == ST_RUN);
    ss_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ditherin_q <= '0;
      pwm_en_q   <= 1'b0;
      ss_done_q  <= 1'b0;
      target_q   <= '0;
      ramp_q     <= '0;
      tick_q     <= '0;
      hold_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values together.
      state_q    <= state_d;
      ditherin_q <= ditherin_d;
      pwm_en_q   <= pwm_en_d;
      ss_done_q  <= ss_done_d;
      target_q   <= target_d;
      ramp_q     <= ramp_d;
      tick_q     <= tick_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.ditherin = ditherin_q;
  assign bus.pwm_en   = pwm_en_q;
  assign bus.state    = state_q;
  assign bus.ss_done  = ss_done_q;

endmodule
